// File: rtl/lcd_bus_driver.sv
// HD44780-style write-cycle generator: turns one byte request into RS/DATA setup,
// an EN strobe, a hold phase and a command-dependent execution wait, then pulses oDone.
module lcd_bus_driver #(
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 16,
    parameter int HOLD_CYC       = 2,
    parameter int EXEC_SHORT_CYC = 2000,
    parameter int EXEC_LONG_CYC  = 82000,
    parameter int CNT_W          = 17
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC,
        S_DONE
    } state_t;

    // Terminal counts: each phase lasts N cycles, so its counter ends at N-1.
    localparam logic [CNT_W-1:0] SETUP_LAST      = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_HIGH_LAST    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST       = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_SHORT_LAST = CNT_W'(EXEC_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LONG_LAST  = CNT_W'(EXEC_LONG_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start_q;
    logic             r_exec_long;
    logic             r_done;
    logic             r_busy;
    logic             r_en;
    logic             r_rs;
    logic [7:0]       r_data;

    logic             w_accept;
    logic             w_exec_last;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_accept    = iStart & ~r_start_q & (r_state == S_IDLE);
    assign w_exec_last = r_exec_long ? (r_cnt == EXEC_LONG_LAST)
                                     : (r_cnt == EXEC_SHORT_LAST);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_start_q   <= 1'b0;
            r_exec_long <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_en        <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_start_q <= iStart;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data      <= iDATA;
                        r_rs        <= iRS;
                        // Clear display (0x01) and return home (0x02/0x03) need the long wait.
                        r_exec_long <= ~iRS & (iDATA[7:2] == 6'd0);
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == EN_HIGH_LAST) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_EXEC: begin
                    if (w_exec_last) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oDone    = r_done;
    assign oBusy    = r_busy;
    assign LCD_DATA = r_data;
    assign LCD_RS   = r_rs;
    assign LCD_EN   = r_en;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shortened timing (2/4/2/10/40 cycles).
module tb_lcd_bus_driver;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [7:0] iDATA;
    logic       iRS;
    logic       iStart;
    logic       oDone;
    logic       oBusy;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] cap_q[$];

    always #5 iCLK = ~iCLK;

    lcd_bus_driver #(
        .SETUP_CYC     (2),
        .EN_HIGH_CYC   (4),
        .HOLD_CYC      (2),
        .EXEC_SHORT_CYC(10),
        .EXEC_LONG_CYC (40),
        .CNT_W         (17)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iDATA   (iDATA),
        .iRS     (iRS),
        .iStart  (iStart),
        .oDone   (oDone),
        .oBusy   (oBusy),
        .LCD_DATA(LCD_DATA),
        .LCD_RW  (LCD_RW),
        .LCD_EN  (LCD_EN),
        .LCD_RS  (LCD_RS)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_done;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller is 1 time unit after a rising edge; the next edge is the accept edge A.
    // Start is held until oDone is seen, then cleared (sequencer-style handshake).
    task automatic run_write(input logic rs, input logic [7:0] data, input int exp_done);
        int   en_rise, en_fall, done_at, done_cnt, en_pulses, unstable;
        logic prev_en;
        iRS    = rs;
        iDATA  = data;
        iStart = 1'b1;
        @(posedge iCLK); #1;
        chk("accept_rs", int'(LCD_RS), int'(rs));
        chk("accept_data", int'(LCD_DATA), int'(data));
        chk("accept_busy", int'(oBusy), 1);
        en_rise = -1; en_fall = -1; done_at = -1; done_cnt = 0;
        en_pulses = 0; unstable = 0; prev_en = LCD_EN;
        for (int k = 1; k <= 200; k++) begin
            @(posedge iCLK); #1;
            iDATA = data ^ 8'(k * 37);
            iRS   = ~rs;
            if (LCD_EN && !prev_en) begin
                en_pulses++;
                if (en_rise < 0) en_rise = k;
                cap_q.push_back(LCD_DATA);
            end
            if (!LCD_EN && prev_en && en_fall < 0) en_fall = k;
            prev_en = LCD_EN;
            if (LCD_RS !== rs || LCD_DATA !== data) unstable++;
            if (oDone) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    chk("busy_at_done", int'(oBusy), 1);
                end
                iStart = 1'b0;
            end
            if (done_at >= 0 && k == done_at + 1) begin
                chk("busy_after_done", int'(oBusy), 0);
                chk("done_one_cycle", int'(oDone), 0);
                break;
            end
        end
        chk("done_latency", done_at, exp_done);
        chk("done_count", done_cnt, 1);
        chk("en_rise", en_rise, 2);
        chk("en_fall", en_fall, 6);
        chk("en_pulses", en_pulses, 1);
        chk("bus_stable", unstable, 0);
        chk("lcd_rw", int'(LCD_RW), 0);
        $display("write rs=%0d data=%02h done@A+%0d en=%0d..%0d", rs, data, done_at, en_rise, en_fall);
    endtask

    initial begin
        int en_pulses, dones;
        logic prev_en;

        tbl[0] = '{1'b1, 8'h41, 18};
        tbl[1] = '{1'b0, 8'h01, 48};
        tbl[2] = '{1'b0, 8'h02, 48};
        tbl[3] = '{1'b0, 8'h38, 18};
        tbl[4] = '{1'b1, 8'h01, 18};
        tbl[5] = '{1'b0, 8'h03, 48};
        tbl[6] = '{1'b0, 8'h04, 18};
        tbl[7] = '{1'b1, 8'h00, 18};

        iRST_N = 1'b0; iDATA = 8'hA5; iRS = 1'b1; iStart = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_done", int'(oDone), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_en", int'(LCD_EN), 0);
        chk("rst_rs", int'(LCD_RS), 0);
        chk("rst_rw", int'(LCD_RW), 0);
        chk("rst_data", int'(LCD_DATA), 0);
        $display("reset released");
        iRST_N = 1'b1;
        @(posedge iCLK); #1;

        foreach (tbl[i]) run_write(tbl[i].rs, tbl[i].data, tbl[i].exp_done);

        // Start held high for 100 cycles with an extra toggle while busy.
        iRS = 1'b1; iDATA = 8'h5A; iStart = 1'b1;
        en_pulses = 0; dones = 0;
        @(posedge iCLK); #1;
        prev_en = LCD_EN;
        for (int k = 1; k < 100; k++) begin
            @(posedge iCLK); #1;
            if (k == 4) iStart = 1'b0;
            if (k == 5) iStart = 1'b1;
            if (LCD_EN && !prev_en) en_pulses++;
            prev_en = LCD_EN;
            if (oDone) dones++;
        end
        chk("held_en_pulses", en_pulses, 1);
        chk("held_dones", dones, 1);
        $display("held start: en pulses=%0d dones=%0d", en_pulses, dones);
        iStart = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;

        // Reset asserted during the EN pulse aborts the write.
        iRS = 1'b1; iDATA = 8'h77; iStart = 1'b1;
        @(posedge iCLK); #1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("abort_en_before", int'(LCD_EN), 1);
        iRST_N = 1'b0; iStart = 1'b0;
        @(posedge iCLK); #1;
        chk("abort_en", int'(LCD_EN), 0);
        chk("abort_busy", int'(oBusy), 0);
        chk("abort_data", int'(LCD_DATA), 0);
        iRST_N = 1'b1;
        dones = 0; en_pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge iCLK); #1;
            if (oDone) dones++;
            if (LCD_EN) en_pulses++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_no_en", en_pulses, 0);
        $display("abort: dones=%0d en cycles=%0d", dones, en_pulses);
        run_write(1'b1, 8'h55, 18);

        // Back-to-back sequencer stream of 22 bytes; EN-captured bytes must match in order.
        cap_q.delete();
        for (int i = 0; i < 22; i++) run_write(1'b1, 8'(8'h30 + i * 7), 18);
        chk("stream_len", cap_q.size(), 22);
        for (int i = 0; i < 22 && i < cap_q.size(); i++)
            chk($sformatf("stream_byte%0d", i), int'(cap_q[i]), int'(8'(8'h30 + i * 7)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
